multi_mode_counter: RTL and testbench
=====================================

# multi_mode_counter

Parametrised, single-clock programmable counter, successor to the dual-mode counter. Supports four run-time counting modes (binary up, binary down, up/down bounce, Gray-coded up) with a programmable modulus, synchronous parallel load, count enable, terminal-count pulse and sticky wrap flag. It serves as a general timebase/sequence generator wherever the design needs a configurable counter instead of a fixed 4-bit one.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  count enable; advance one step per enabled cycle
- mode  in  2  00 binary up, 01 binary down, 10 bounce, 11 Gray up
- max_val  in  WIDTH  upper bound of the count range, inclusive; range is 0..max_val
- load  in  1  synchronous load request
- load_val  in  WIDTH  value loaded on load (binary, any mode)
- clr_wrap  in  1  clears sticky wrap flag
- count  out  WIDTH  registered count; binary in modes 00/01/10, Gray code of internal binary value in mode 11
- dir  out  1  registered direction, 1 = up, 0 = down
- tc  out  1  registered one-cycle terminal-count pulse
- wrapped  out  1  sticky flag, set by any tc

## Operation
- State: internal binary register bin[WIDTH-1:0], dir register; count derived from next bin and registered.
- Priority per edge: rst low > load > en. With en low and no load, bin, dir and count hold, and tc = 0.
- Reset (rst = 0 at edge): bin = 0, count = 0, dir = 1, tc = 0, wrapped = 0.
- Load: bin = min(load_val, max_val), dir = 1, tc = 0. Load takes effect regardless of en.
- Mode 00 (up): bin == max_val → 0 with tc = 1; otherwise bin + 1.
- Mode 01 (down): bin == 0 → max_val with tc = 1; otherwise bin − 1.
- Mode 10 (bounce):
  - dir = 1 and bin == max_val → bin = max_val − 1, dir = 0, tc = 1.
  - dir = 0 and bin == 0 → bin = 1, dir = 1, tc = 1.
  - Otherwise step in direction dir.
- Mode 11 (Gray up): bin steps as in mode 00; count = bin ^ (bin >> 1).
- In modes 00, 01 and 11, dir is forced to 1 on every enabled edge. On entry to mode 10, dir retains its current value.
- max_val == 0: bin stays 0 and tc = 1 on every enabled edge, in all modes. Bounce mode does not step to 1.
- Out-of-range (bin > max_val, e.g. max_val lowered at run time): the next enabled edge sets bin to the mode start value (0 for 00/10/11 with dir = 1; max_val for 01), with tc = 0.
- Mode and max_val are sampled every edge. A change takes effect on the next enabled edge from the current bin value, with no reset of bin.
- wrapped: set on any edge that asserts tc. clr_wrap clears it. If tc and clr_wrap occur on the same edge, set wins.
- All arithmetic is modulo 2^WIDTH in binary. The ±1 never overflows, because endpoints are handled explicitly.

## Timing
- Latency: count, dir and tc reflect the edge that computes them (one register stage). There is no combinational path from inputs to outputs.
- tc is high for exactly one cycle per wrap or turnaround. With en held high and max_val = N in mode 00, tc has period N + 1 cycles.
- Mode 11 with en held high: count changes exactly one bit per enabled edge, including the max_val → 0 wrap when max_val + 1 is a power of two.
- Reset mid-count: outputs are 0 on the cycle after the reset edge. Counting resumes on the first enabled edge with rst high, producing 1.

## Test plan
- Reset then mode 00, max_val = 5, en = 1 for 14 cycles -> count 1,2,3,4,5,0,1,…; tc high in the cycles where count = 0; wrapped = 1 after the first wrap.
- Mode 01, max_val = 3, load = 1 with load_val = 9 -> count = 3 (clamped); then en = 1 gives 2,1,0,3 with tc at the 3.
- Mode 10, max_val = 3, from reset, en = 1 -> count 1,2,3,2,1,0,1; dir falls when count reaches 2 after 3; tc on the 3→2 and 0→1 edges.
- Mode 11, WIDTH = 4, max_val = 15, 16 enabled cycles -> count follows Gray sequence 0001,0011,0010,…,1000,0000; Hamming distance 1 between every pair of consecutive values.
- Run time: count = 7 with max_val = 10, change to max_val = 4 -> next enabled edge gives count 0 with tc = 0. Same cycle tc plus clr_wrap -> wrapped stays 1.
- rst = 0 asserted together with load = 1 and en = 1 at count = 6 -> next cycle count = 0, tc = 0, dir = 1, wrapped = 0; en low for 3 cycles -> count holds.

Source files
------------

// File: rtl/multi_mode_counter_if.sv
// Purpose: control/status bundle of multi_mode_counter.
// Ports:
//   en, mode, max_val, load, load_val, clr_wrap : counter controls (master -> slave)
//   count, dir, tc, wrapped                      : registered status (slave -> master)
interface multi_mode_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] max_val;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_wrap;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, mode, max_val, load, load_val, clr_wrap,
    input  count, dir, tc, wrapped
  );

  modport slave (
    input  en, mode, max_val, load, load_val, clr_wrap,
    output count, dir, tc, wrapped
  );
endinterface

// File: rtl/multi_mode_counter.sv
// Purpose: programmable counter with up, down, bounce and Gray-up modes,
//          programmable inclusive modulus, parallel load, terminal-count
//          pulse and sticky wrap flag.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : multi_mode_counter_if.slave (controls in, registered status out)
module multi_mode_counter #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  multi_mode_counter_if.slave  bus
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_GRAY   = 2'b11;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;

  // Next-state computation: load beats enable; endpoints handled explicitly
  always_comb begin
    bin_d     = bin_q;
    dir_d     = dir_q;
    tc_d      = 1'b0;
    count_d   = count_q;
    wrapped_d = wrapped_q;

    if (bus.load) begin
      bin_d = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
      dir_d = 1'b1;
    end else if (bus.en) begin
      if (bus.max_val == '0) begin
        // Degenerate range: every enabled edge is a terminal count
        bin_d = '0;
        tc_d  = 1'b1;
        dir_d = (bus.mode == MODE_BOUNCE) ? dir_q : 1'b1;
      end else if (bin_q > bus.max_val) begin
        // Modulus lowered below the current value: restart quietly
        bin_d = (bus.mode == MODE_DOWN) ? bus.max_val : '0;
        dir_d = 1'b1;
      end else begin
        case (bus.mode)
          MODE_DOWN: begin
            dir_d = 1'b1;
            if (bin_q == '0) begin
              bin_d = bus.max_val;
              tc_d  = 1'b1;
            end else begin
              bin_d = bin_q - WIDTH'(1);
            end
          end
          MODE_BOUNCE: begin
            if (dir_q && (bin_q == bus.max_val)) begin
              bin_d = bin_q - WIDTH'(1);
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end else if (!dir_q && (bin_q == '0)) begin
              bin_d = WIDTH'(1);
              dir_d = 1'b1;
              tc_d  = 1'b1;
            end else if (dir_q) begin
              bin_d = bin_q + WIDTH'(1);
            end else begin
              bin_d = bin_q - WIDTH'(1);
            end
          end
          default: begin
            // Up and Gray-up share the binary sequence
            dir_d = 1'b1;
            if (bin_q == bus.max_val) begin
              bin_d = '0;
              tc_d  = 1'b1;
            end else begin
              bin_d = bin_q + WIDTH'(1);
            end
          end
        endcase
      end
    end

    // Output encoding follows the mode in force on the updating edge
    if (bus.load || bus.en) begin
      count_d = (bus.mode == MODE_GRAY) ? (bin_d ^ (bin_d >> 1)) : bin_d;
    end

    // Set wins over clear
    if (tc_d) begin
      wrapped_d = 1'b1;
    end else if (bus.clr_wrap) begin
      wrapped_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q     <= '0;
      count_q   <= '0;
      dir_q     <= 1'b1;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.dir     = dir_q;
  assign bus.tc      = tc_q;
  assign bus.wrapped = wrapped_q;

  // MODE_UP is covered by the default arm of the mode case
  logic unused_mode_up;
  assign unused_mode_up = ^MODE_UP;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Purpose: self-checking bench for multi_mode_counter: directed vector table,
//          Gray-sequence walk, and randomized run against a behavioural model.
module tb_multi_mode_counter;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] max_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_wrap;
    logic [WIDTH-1:0] exp_count;
    logic             exp_dir;
    logic             exp_tc;
    logic             exp_wrapped;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  vec_t vecs[$];

  multi_mode_counter_if #(.WIDTH(WIDTH)) bus_if ();

  multi_mode_counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [WIDTH-1:0] mx, input logic ld,
                       input logic [WIDTH-1:0] lv, input logic clr);
    rst             = r;
    bus_if.en       = e;
    bus_if.mode     = m;
    bus_if.max_val  = mx;
    bus_if.load     = ld;
    bus_if.load_val = lv;
    bus_if.clr_wrap = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic e, input logic [1:0] m,
                              input int mx, input logic ld, input int lv,
                              input logic clr, input int ec, input logic ed,
                              input logic et, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.max_val = WIDTH'(mx); v.load = ld;
    v.load_val = WIDTH'(lv); v.clr_wrap = clr; v.exp_count = WIDTH'(ec);
    v.exp_dir = ed; v.exp_tc = et; v.exp_wrapped = ew;
    vecs.push_back(v);
  endfunction

  // Behavioural reference model, expressed in plain integer arithmetic
  int m_bin, m_dir, m_cnt, m_tc, m_wr;

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  function automatic void model_step(input int r, input int e, input int m,
                                     input int mx, input int ld, input int lv,
                                     input int clr);
    if (r == 0) begin
      m_bin = 0; m_dir = 1; m_cnt = 0; m_tc = 0; m_wr = 0;
      return;
    end
    m_tc = 0;
    if (ld != 0) begin
      m_bin = (lv < mx) ? lv : mx;
      m_dir = 1;
    end else if (e != 0) begin
      if (mx == 0) begin
        m_bin = 0;
        m_tc  = 1;
        if (m != 2) m_dir = 1;
      end else if (m_bin > mx) begin
        m_bin = (m == 1) ? mx : 0;
        m_dir = 1;
      end else if (m == 1) begin
        m_tc  = (m_bin == 0);
        m_bin = (m_bin + mx) % (mx + 1);
        m_dir = 1;
      end else if (m == 2) begin
        if ((m_dir == 1 && m_bin == mx) || (m_dir == 0 && m_bin == 0)) begin
          m_dir = 1 - m_dir;
          m_tc  = 1;
        end
        m_bin = m_bin + ((m_dir == 1) ? 1 : -1);
      end else begin
        m_tc  = (m_bin == mx);
        m_bin = (m_bin + 1) % (mx + 1);
        m_dir = 1;
      end
    end
    if (ld != 0 || e != 0) m_cnt = (m == 3) ? gray(m_bin) : m_bin;
    if (m_tc != 0) m_wr = 1;
    else if (clr != 0) m_wr = 0;
  endfunction

  initial begin
    logic [WIDTH-1:0] prev;
    int               mx;
    drive(1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0);

    // Reset, then up count mod 6
    add(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 14; i++)
      add(1, 1, 2'b00, 5, 0, 0, 0, i % 6, 1, (i % 6) == 0, i >= 6);
    // Load clamps to max_val, clear wrap on same edge, then count down
    add(1, 0, 2'b01, 3, 1, 9, 1, 3, 1, 0, 0);
    add(1, 1, 2'b01, 3, 0, 0, 0, 2, 1, 0, 0);
    add(1, 1, 2'b01, 3, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 2'b01, 3, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 2'b01, 3, 0, 0, 0, 3, 1, 1, 1);
    // Bounce from reset
    add(0, 0, 2'b10, 3, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 2'b10, 3, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 2'b10, 3, 0, 0, 0, 2, 1, 0, 0);
    add(1, 1, 2'b10, 3, 0, 0, 0, 3, 1, 0, 0);
    add(1, 1, 2'b10, 3, 0, 0, 0, 2, 0, 1, 1);
    add(1, 1, 2'b10, 3, 0, 0, 0, 1, 0, 0, 1);
    add(1, 1, 2'b10, 3, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 2'b10, 3, 0, 0, 0, 1, 1, 1, 1);
    // Modulus lowered below count: quiet restart; tc with clr_wrap keeps wrapped
    add(0, 0, 2'b00, 10, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) add(1, 1, 2'b00, 10, 0, 0, 0, i, 1, 0, 0);
    add(1, 1, 2'b00, 4, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 1, 2'b00, 4, 0, 0, 0, i, 1, 0, 0);
    add(1, 1, 2'b00, 4, 0, 0, 1, 0, 1, 1, 1);
    add(1, 0, 2'b00, 4, 0, 0, 1, 0, 1, 0, 0);
    // Reset beats load and enable, then hold
    for (int i = 1; i <= 6; i++) add(1, 1, 2'b00, 10, 0, 0, 0, i, 1, 0, 0);
    add(0, 1, 2'b00, 10, 1, 9, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 2'b00, 10, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 2'b00, 10, 0, 0, 0, 1, 1, 0, 0);
    // Down mode out-of-range restarts at max_val; max_val 0 pulses tc
    add(1, 0, 2'b00, 10, 1, 8, 0, 8, 1, 0, 0);
    add(1, 1, 2'b01, 5, 0, 0, 0, 5, 1, 0, 0);
    add(1, 1, 2'b10, 0, 0, 0, 0, 0, 1, 1, 1);
    add(1, 1, 2'b10, 0, 0, 0, 0, 0, 1, 1, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].max_val,
            vecs[i].load, vecs[i].load_val, vecs[i].clr_wrap);
      tick();
      check($sformatf("vec%0d.count", i), int'(bus_if.count), int'(vecs[i].exp_count));
      check($sformatf("vec%0d.dir", i), int'(bus_if.dir), int'(vecs[i].exp_dir));
      check($sformatf("vec%0d.tc", i), int'(bus_if.tc), int'(vecs[i].exp_tc));
      check($sformatf("vec%0d.wrapped", i), int'(bus_if.wrapped), int'(vecs[i].exp_wrapped));
    end

    // Gray walk over a power-of-two range: single-bit steps incl. the wrap
    drive(1'b0, 1'b0, 2'b11, 8'd15, 1'b0, '0, 1'b0);
    tick();
    check("gray.reset", int'(bus_if.count), 0);
    prev = bus_if.count;
    drive(1'b1, 1'b1, 2'b11, 8'd15, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("gray%0d.count", i), int'(bus_if.count), gray(i % 16));
      check($sformatf("gray%0d.hamming", i), $countones(bus_if.count ^ prev), 1);
      check($sformatf("gray%0d.tc", i), int'(bus_if.tc), (i == 16) ? 1 : 0);
      prev = bus_if.count;
    end

    // Randomized run against the model
    drive(1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0);
    model_step(0, 0, 0, 0, 0, 0, 0);
    tick();
    mx = 6;
    for (int i = 0; i < 600; i++) begin
      logic             r, e, ld, clr;
      logic [1:0]       m;
      logic [WIDTH-1:0] lv;
      if ($urandom_range(0, 19) == 0) mx = $urandom_range(0, 12);
      if ($urandom_range(0, 99) == 0) mx = $urandom_range(0, 255);
      r   = ($urandom_range(0, 49) != 0);
      e   = ($urandom_range(0, 9) < 7);
      ld  = ($urandom_range(0, 14) == 0);
      clr = ($urandom_range(0, 9) == 0);
      m   = 2'($urandom_range(0, 3));
      lv  = WIDTH'($urandom_range(0, 15));
      drive(r, e, m, WIDTH'(mx), ld, lv, clr);
      model_step(int'(r), int'(e), int'(m), mx, int'(ld), int'(lv), int'(clr));
      tick();
      check($sformatf("rnd%0d.count", i), int'(bus_if.count), m_cnt);
      check($sformatf("rnd%0d.dir", i), int'(bus_if.dir), m_dir);
      check($sformatf("rnd%0d.tc", i), int'(bus_if.tc), m_tc);
      check($sformatf("rnd%0d.wrapped", i), int'(bus_if.wrapped), m_wr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
